// File: rtl/dmem_ctrl.sv
// Data-memory controller with a fixed multi-cycle access latency.
// A request seen in IDLE raises stall_o at once; the access completes
// LATENCY cycles later in a one-cycle DONE state that pulses done_o.
module dmem_ctrl #(
  parameter int LATENCY = 3,
  parameter int AW      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  state_t        state;
  logic [3:0]    cnt;

  // Request captured in IDLE; later changes on the inputs are ignored.
  logic          lat_rd;
  logic          lat_wr;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic          lat_mis;

  // Effective request: live inputs while in IDLE, latched copy afterwards.
  logic          req;
  logic          eff_rd;
  logic          eff_wr;
  logic [AW-1:0] eff_idx;
  logic [31:0]   eff_data;
  logic          eff_mis;
  logic          go_done;
  logic          unused_addr;

  logic [31:0]   mem [0:(1<<AW)-1];

  // Select the request that is active this cycle and decide completion.
  // cnt counts the remaining stall cycles including the current one, so
  // ACCESS finishes when it reaches 1; LATENCY=1 skips ACCESS entirely.
  always_comb begin
    req         = MemRead_i | MemWrite_i;
    unused_addr = ^addr_i[31:AW+2];
    if (state == IDLE) begin
      eff_wr   = MemWrite_i;
      eff_rd   = MemRead_i & ~MemWrite_i;
      eff_idx  = addr_i[AW+1:2];
      eff_data = data_i;
      eff_mis  = |addr_i[1:0];
    end else begin
      eff_wr   = lat_wr;
      eff_rd   = lat_rd;
      eff_idx  = lat_idx;
      eff_data = lat_data;
      eff_mis  = lat_mis;
    end
    go_done = ((state == IDLE) && req && SINGLE) ||
              ((state == ACCESS) && (cnt <= 4'd1));
  end

  // Stall is combinational so the pipeline freezes in the request cycle.
  always_comb begin
    stall_o = rst_i && (((state == IDLE) && req) || (state == ACCESS));
  end

  // Storage: writes commit on the edge entering DONE; never reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && go_done && eff_wr) begin
      mem[eff_idx] <= eff_data;
    end
  end

  // Controller FSM with registered completion outputs and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      data_o     <= '0;
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_idx    <= '0;
      lat_data   <= '0;
      lat_mis    <= 1'b0;
    end else begin
      done_o     <= go_done;
      misalign_o <= go_done & eff_mis;
      if (go_done && eff_rd) begin
        data_o <= mem[eff_idx];
      end
      case (state)
        IDLE: begin
          if (req) begin
            lat_rd   <= MemRead_i & ~MemWrite_i;
            lat_wr   <= MemWrite_i;
            lat_idx  <= addr_i[AW+1:2];
            lat_data <= data_i;
            lat_mis  <= |addr_i[1:0];
            if (SINGLE) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              state <= ACCESS;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ACCESS: begin
          if (cnt <= 4'd1) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with LATENCY=3, one with
// LATENCY=1. Stimulus pushes expected completions; a negedge monitor pops
// and checks them whenever done_o is seen.
module tb_dmem_ctrl;

  localparam int LAT [2] = '{3, 1};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] data  [2];
  logic        stall [2];
  logic [31:0] dout  [2];
  logic        done  [2];
  logic        mis   [2];

  dmem_ctrl #(.LATENCY(3), .AW(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .addr_i(addr[0]), .data_i(data[0]), .stall_o(stall[0]),
    .data_o(dout[0]), .done_o(done[0]), .misalign_o(mis[0])
  );

  dmem_ctrl #(.LATENCY(1), .AW(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .addr_i(addr[1]), .data_i(data[1]), .stall_o(stall[1]),
    .data_o(dout[1]), .done_o(done[1]), .misalign_o(mis[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          lat;
    bit          gap;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          scnt [2];
  int          last_done [2];
  bit          prev_done [2];
  logic [31:0] mdl0 [int];
  logic [31:0] mdl1 [int];
  logic [31:0] last_rd [2];

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rdm(int g, int idx);
    if (g == 0) return mdl0.exists(idx) ? mdl0[idx] : 32'h0;
    return mdl1.exists(idx) ? mdl1[idx] : 32'h0;
  endfunction

  function automatic void push(int g, exp_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Monitor: pop an expectation on every done_o and check timing/data.
  task automatic mon(int g);
    exp_t e;
    bit   empty;
    if (!rst[g]) begin
      scnt[g]      = 0;
      prev_done[g] = 1'b0;
      return;
    end
    if (prev_done[g]) begin
      chk($sformatf("done_width%0d", g), {31'b0, done[g]}, 32'd0);
      chk($sformatf("mis_width%0d", g), {31'b0, mis[g]}, 32'd0);
    end
    if (stall[g]) scnt[g]++;
    if (done[g]) begin
      empty = (g == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done%0d: done_o=1 with no access pending (t=%0t)", g, $time);
      end else begin
        if (g == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("data%0d", g), dout[g], e.data);
        chk($sformatf("misalign%0d", g), {31'b0, mis[g]}, {31'b0, e.mis});
        chk($sformatf("stall_cycles%0d", g), scnt[g], e.lat);
        chk($sformatf("stall_at_done%0d", g), {31'b0, stall[g]}, 32'd0);
        if (e.gap) chk($sformatf("done_gap%0d", g), cyc - last_done[g], e.lat + 1);
      end
      last_done[g] = cyc;
      scnt[g]      = 0;
    end
    prev_done[g] = done[g];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One access, entered at posedge+1 of an IDLE cycle; returns likewise.
  task automatic do_access(int g, bit r, bit w, logic [31:0] a, logic [31:0] d, bit scr);
    exp_t        e;
    logic [31:0] ev;
    int          idx;
    bit          seen;
    idx = int'(a[9:2]);
    if (w) begin
      if (g == 0) mdl0[idx] = d;
      else        mdl1[idx] = d;
      ev = last_rd[g];
    end else begin
      ev = rdm(g, idx);
      last_rd[g] = ev;
    end
    e.data = ev;
    e.mis  = (a[1:0] != 2'b00);
    e.lat  = LAT[g];
    e.gap  = 1'b0;
    push(g, e);
    rd[g] = r; wr[g] = w; addr[g] = a; data[g] = d;
    if (scr) begin
      @(posedge clk); #1;
      rd[g] = ~r; wr[g] = ~w; addr[g] = a ^ 32'h40; data[g] = ~d;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done[g];
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout%0d: no done_o for addr %h", g, a);
    end
    rd[g] = 1'b0; wr[g] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   n;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0; rd[g] = 1'b0; wr[g] = 1'b0;
      addr[g] = '0; data[g] = '0; last_rd[g] = '0;
      scnt[g] = 0; last_done[g] = 0; prev_done[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_stall%0d", g), {31'b0, stall[g]}, 32'd0);
      chk($sformatf("rst_done%0d", g), {31'b0, done[g]}, 32'd0);
      chk($sformatf("rst_mis%0d", g), {31'b0, mis[g]}, 32'd0);
      chk($sformatf("rst_data%0d", g), dout[g], 32'd0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b1; rst[1] = 1'b1;

    // LATENCY=3 instance
    do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    do_access(0, 1, 0, 32'h10, 32'h0, 0);
    do_access(0, 1, 1, 32'h20, 32'h12345678, 0);
    do_access(0, 1, 0, 32'h20, 32'h0, 0);
    do_access(0, 0, 1, 32'h10, 32'hA5A5A5A5, 0);
    do_access(0, 1, 0, 32'h13, 32'h0, 0);
    do_access(0, 0, 1, 32'h44, 32'hCAFEF00D, 1);
    do_access(0, 1, 0, 32'h44, 32'h0, 0);
    do_access(0, 1, 0, 32'h10, 32'h0, 0);
    do_access(0, 0, 1, 32'h30, 32'h11111111, 0);

    // Reset in the second ACCESS cycle of a write to 0x30 aborts it
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h30; data[0] = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    rst[0] = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall[0]}, 32'd0);
    chk("abort_done", {31'b0, done[0]}, 32'd0);
    chk("abort_data", dout[0], 32'd0);
    last_rd[0] = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    do_access(0, 1, 0, 32'h30, 32'h0, 0);

    // Two reads with the request held high across DONE
    e.data = 32'hA5A5A5A5; e.mis = 1'b0; e.lat = LAT[0]; e.gap = 1'b0;
    q0.push_back(e);
    e.gap = 1'b1;
    q0.push_back(e);
    last_rd[0] = 32'hA5A5A5A5;
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (done[0]) n++;
    end
    rd[0] = 1'b0;
    chk("held_read_dones", n, 2);
    @(posedge clk); #1;

    // Address wrap on the LATENCY=3 instance
    do_access(0, 0, 1, 32'h0000_0404, 32'h0BADC0DE, 0);
    do_access(0, 1, 0, 32'h0000_0004, 32'h0, 0);

    // LATENCY=1 instance
    do_access(1, 0, 1, 32'h000, 32'h77, 0);
    do_access(1, 1, 0, 32'h400, 32'h0, 0);
    do_access(1, 0, 1, 32'h0F7, 32'h89ABCDEF, 0);
    do_access(1, 1, 0, 32'h0F4, 32'h0, 0);
    do_access(1, 1, 1, 32'h020, 32'h13572468, 0);
    do_access(1, 1, 0, 32'h422, 32'h0, 0);

    for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    chk("queue_drain", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
